// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
//   ptr_w()        : pointer width for a given depth (address bits + wrap bit)
//   DEF_*          : default parameter values for synch_fifo_param
//   fifo_status_t  : status bundle {f, e, af, ae, ovf, udf} for wrappers that
//                    want to pass FIFO state around as a single signal
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_AF_LVL = 6;
  localparam int DEF_AE_LVL = 2;

  // One extra bit above the address distinguishes full from empty when the
  // address bits of the two pointers are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic f;
    logic e;
    logic af;
    logic ae;
    logic ovf;
    logic udf;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array for the FIFO.
//   clk    : write clock (rising edge)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
// Contents are never reset.
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, thresholds and sticky errors.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   we/din   : write request and data
//   re       : read request
//   clr_err  : clears ovf/udf (a same-cycle set takes priority)
//   dout     : registered read data; dout_vld pulses when it was updated
//   f/e      : full / empty
//   af/ae    : count >= AF_LVL / count <= AE_LVL
//   count    : occupancy 0..DEPTH
//   ovf/udf  : sticky write-while-full / read-while-empty
module synch_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [DATA_W-1:0]      din,
  input  logic                   re,
  input  logic                   clr_err,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_vld,
  output logic                   f,
  output logic                   e,
  output logic                   af,
  output logic                   ae,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]     wp, rp;
  logic [PW-1:0]     cnt;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              ovf_q, udf_q;
  logic              full, empty;
  logic              bypass, wr_en, rd_en;
  logic              ovf_set, udf_set;
  fifo_status_t      status;

  // Stage 0: pointer-derived status and request qualification
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cnt   = wp - rp;

  // Simultaneous read and write on an empty FIFO passes din straight to dout
  // without touching the array, so neither pointer moves.
  assign bypass  = we && re && empty;
  // When full, a concurrent read frees the slot on the same edge.
  assign wr_en   = we && !bypass && (!full || re);
  assign rd_en   = re && !empty;
  assign ovf_set = we && full && !re;
  assign udf_set = re && empty && !we;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && rst),
    .waddr (wp[AW-1:0]),
    .wdata (din),
    .raddr (rp[AW-1:0]),
    .rdata (rdata)
  );

  // Stage 1: registered pointers, read data, strobe and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp      <= '0;
      rp      <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + PW'(1);
      if (rd_en) rp <= rp + PW'(1);
      if (rd_en)       dout_p1 <= rdata;
      else if (bypass) dout_p1 <= din;
      vld_p1 <= rd_en || bypass;
      ovf_q  <= ovf_set || (ovf_q && !clr_err);
      udf_q  <= udf_set || (udf_q && !clr_err);
    end
  end

  assign status = '{
    f:   full,
    e:   empty,
    af:  (cnt >= PW'(AF_LVL)),
    ae:  (cnt <= PW'(AE_LVL)),
    ovf: ovf_q,
    udf: udf_q
  };

  assign dout     = dout_p1;
  assign dout_vld = vld_p1;
  assign count    = cnt;
  assign f        = status.f;
  assign e        = status.e;
  assign af       = status.af;
  assign ae       = status.ae;
  assign ovf      = status.ovf;
  assign udf      = status.udf;

endmodule

// File: tb/tb_synch_fifo_param.sv
module tb_synch_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default 8x8, thresholds 6/2
  logic       rst, we, re, clr_err;
  logic [7:0] din, dout;
  logic       dout_vld, f, e, af, ae, ovf, udf;
  logic [3:0] count;

  synch_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) dut_a (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .clr_err(clr_err),
    .dout(dout), .dout_vld(dout_vld), .f(f), .e(e), .af(af), .ae(ae),
    .count(count), .ovf(ovf), .udf(udf)
  );

  // DUT B: 16 x 32
  logic        b_rst, b_we, b_re, b_clr;
  logic [31:0] b_din, b_dout;
  logic        b_vld, b_f, b_e, b_af, b_ae, b_ovf, b_udf;
  logic [4:0]  b_count;

  synch_fifo_param #(.DATA_W(32), .DEPTH(16), .AF_LVL(12), .AE_LVL(3)) dut_b (
    .clk(clk), .rst(b_rst), .we(b_we), .din(b_din), .re(b_re), .clr_err(b_clr),
    .dout(b_dout), .dout_vld(b_vld), .f(b_f), .e(b_e), .af(b_af), .ae(b_ae),
    .count(b_count), .ovf(b_ovf), .udf(b_udf)
  );

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: a queue of stored words plus output registers.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_vld, m_ovf, m_udf;

  task automatic model_update(input logic r, input logic w, input logic rd,
                              input logic c, input logic [7:0] d);
    bit full, emp;
    if (!r) begin
      mq.delete();
      m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      full  = (mq.size() == 8);
      emp   = (mq.size() == 0);
      m_vld = 1'b0;
      if (w && rd && emp) begin
        m_dout = d; m_vld = 1'b1;
      end else begin
        if (rd && !emp) begin
          m_dout = mq.pop_front(); m_vld = 1'b1;
        end
        if (w && (!full || rd)) mq.push_back(d);
      end
      if (w && full && !rd) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (rd && emp && !w)  m_udf = 1'b1; else if (c) m_udf = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".dout"},  32'(dout), 32'(m_dout));
    chk({tag, ".vld"},   32'(dout_vld), 32'(m_vld));
    chk({tag, ".f"},     32'(f),  32'(n == 8));
    chk({tag, ".e"},     32'(e),  32'(n == 0));
    chk({tag, ".af"},    32'(af), 32'(n >= 6));
    chk({tag, ".ae"},    32'(ae), 32'(n <= 2));
    chk({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"},   32'(udf), 32'(m_udf));
  endtask

  // Apply one cycle of inputs to DUT A, sample #1 after the edge.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic c, input logic [7:0] d);
    rst = r; we = w; re = rd; clr_err = c; din = d;
    @(posedge clk);
    #1;
    model_update(r, w, rd, c, d);
    we = 1'b0; re = 1'b0; clr_err = 1'b0; rst = 1'b1;
  endtask

  typedef struct {
    logic       rst, we, re, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       vld, ovf, udf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic w, input logic rd, input logic c,
                              input logic [7:0] d, input int cn, input logic [7:0] o,
                              input logic v, input logic ov, input logic ud);
    vec_t x;
    x.rst = r; x.we = w; x.re = rd; x.clr = c; x.din = d;
    x.cnt = cn; x.dout = o; x.vld = v; x.ovf = ov; x.udf = ud;
    tbl.push_back(x);
  endfunction

  task automatic stepb(input logic r, input logic w, input logic rd,
                       input logic c, input logic [31:0] d);
    b_rst = r; b_we = w; b_re = rd; b_clr = c; b_din = d;
    @(posedge clk);
    #1;
    b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0; b_rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0; din = 8'h00;
    b_rst = 1'b0; b_we = 1'b0; b_re = 1'b0; b_clr = 1'b0; b_din = 32'h0;

    // Directed table: reset, fill, overflow, full-simultaneous, error clear,
    // drain, underflow, empty bypass, reset mid-operation.
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 0, 8'(i), i, 8'h00, 0, 0, 0);
    add(1, 1, 0, 0, 8'h09, 8, 8'h00, 0, 1, 0);
    add(1, 1, 1, 0, 8'hAA, 8, 8'h01, 1, 1, 0);
    add(1, 1, 0, 1, 8'hBB, 8, 8'h01, 0, 1, 0);
    add(1, 0, 0, 1, 8'h00, 8, 8'h01, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 8'h00, 7 - i, 8'(i + 2), 1, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 8'hAA, 1, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 8'hAA, 0, 0, 1);
    add(1, 1, 1, 0, 8'h55, 0, 8'h55, 1, 0, 1);
    add(1, 0, 0, 1, 8'h00, 0, 8'h55, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 8'(8'h10 + i), i + 1, 8'h55, 0, 0, 0);
    add(0, 1, 0, 0, 8'h99, 0, 8'h00, 0, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].we, tbl[k].re, tbl[k].clr, tbl[k].din);
      chk($sformatf("v%0d.count", k), 32'(count), 32'(tbl[k].cnt));
      chk($sformatf("v%0d.dout", k),  32'(dout), 32'(tbl[k].dout));
      chk($sformatf("v%0d.vld", k),   32'(dout_vld), 32'(tbl[k].vld));
      chk($sformatf("v%0d.f", k),     32'(f),  32'(tbl[k].cnt == 8));
      chk($sformatf("v%0d.e", k),     32'(e),  32'(tbl[k].cnt == 0));
      chk($sformatf("v%0d.af", k),    32'(af), 32'(tbl[k].cnt >= 6));
      chk($sformatf("v%0d.ae", k),    32'(ae), 32'(tbl[k].cnt <= 2));
      chk($sformatf("v%0d.ovf", k),   32'(ovf), 32'(tbl[k].ovf));
      chk($sformatf("v%0d.udf", k),   32'(udf), 32'(tbl[k].udf));
    end

    // Wrap: 5 writes then 5 reads, four times, against the model.
    step(1, 0, 0, 1, 8'h00);
    check_model("wrap_clr");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(1, 1, 0, 0, 8'($urandom_range(255)));
        check_model($sformatf("wrap%0d_w%0d", r, i));
      end
      for (int i = 0; i < 5; i++) begin
        step(1, 0, 1, 0, 8'h00);
        check_model($sformatf("wrap%0d_r%0d", r, i));
      end
    end

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      logic w, rd, c, r;
      w  = ($urandom_range(99) < 55);
      rd = ($urandom_range(99) < 50);
      c  = ($urandom_range(99) < 5);
      r  = ($urandom_range(199) != 0);
      step(r, w, rd, c, 8'($urandom_range(255)));
      check_model($sformatf("rnd%0d", n));
    end

    // 16 x 32 instance: fill, overflow, clear against a same-cycle set.
    stepb(0, 0, 0, 0, 32'h0);
    chk("b.rst_count", 32'(b_count), 32'd0);
    chk("b.rst_e", 32'(b_e), 32'd1);
    for (int i = 1; i <= 16; i++) stepb(1, 1, 0, 0, 32'h01010101 * 32'(i));
    chk("b.full_count", 32'(b_count), 32'd16);
    chk("b.full_f", 32'(b_f), 32'd1);
    chk("b.full_af", 32'(b_af), 32'd1);
    chk("b.full_ovf", 32'(b_ovf), 32'd0);
    stepb(1, 1, 0, 0, 32'hDEADBEEF);
    chk("b.ovf_set", 32'(b_ovf), 32'd1);
    chk("b.ovf_count", 32'(b_count), 32'd16);
    stepb(1, 1, 0, 1, 32'hCAFEF00D);
    chk("b.ovf_setwins", 32'(b_ovf), 32'd1);
    stepb(1, 0, 0, 1, 32'h0);
    chk("b.ovf_clr", 32'(b_ovf), 32'd0);
    stepb(1, 0, 1, 0, 32'h0);
    chk("b.rd_dout", b_dout, 32'h01010101);
    chk("b.rd_vld", 32'(b_vld), 32'd1);
    chk("b.rd_count", 32'(b_count), 32'd15);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
